// File: rtl/conv_tree_pkg.sv
// Shared parameters and types for the DDR tree deserializer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package conv_tree_pkg;

    localparam int WORD_W     = 16;
    localparam int PAIRS      = 8;
    localparam int FIFO_DEPTH = 2;

    localparam int CNT_W = $clog2(PAIRS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [PTR_W-1:0]  ptr_t;
    typedef logic [OCC_W-1:0]  occ_t;

    // One rising-edge-aligned bit pair: fall holds bit 2k+1, rise holds bit 2k.
    typedef struct packed {
        logic fall;
        logic rise;
    } pair_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam cnt_t LAST_PAIR = cnt_t'(PAIRS - 1);
    localparam occ_t FIFO_FULL = occ_t'(FIFO_DEPTH);

endpackage

// File: rtl/conv_tree_deserializer_16_if.sv
// Parallel word output handshake of the deserializer.
// Latency: n/a (wiring only).
// Backpressure: consumer holds PAR_READY low to stall; word stays on PAR_OUT.
interface conv_tree_deserializer_16_if;
    import conv_tree_pkg::*;

    word_t PAR_OUT;
    logic  PAR_VALID;
    logic  PAR_READY;

    modport master (
        output PAR_OUT,
        output PAR_VALID,
        input  PAR_READY
    );

    modport slave (
        input  PAR_OUT,
        input  PAR_VALID,
        output PAR_READY
    );

endinterface

// File: rtl/conv_tree_deserializer_16_capture.sv
// DDR input capture: samples SERIAL_IN on both edges, presents {fall, rise} pair.
// Latency: pair captured at rising edge Ek and the following falling edge is valid at E(k+1).
// Backpressure: none; free-running capture.
module ddr_input_capture
    import conv_tree_pkg::*;
(
    input  logic  CLK,
    input  logic  RESET,
    input  logic  SERIAL_IN,
    output pair_t pair_o
);

    logic rise_q;
    logic fall_q;

    // Even bit of the pair: sampled on the rising edge.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rise_q <= 1'b0;
        end else begin
            rise_q <= SERIAL_IN;
        end
    end

    // Odd bit of the pair: the only falling-edge flop in the block.
    always_ff @(negedge CLK or negedge RESET) begin
        if (!RESET) begin
            fall_q <= 1'b0;
        end else begin
            fall_q <= SERIAL_IN;
        end
    end

    // Both flops are stable at the next rising edge, so the pair is rising-edge aligned.
    always_comb begin
        pair_o      = '0;
        pair_o.fall = fall_q;
        pair_o.rise = rise_q;
    end

endmodule

// File: rtl/conv_tree_deserializer_16.sv
// Reassembles 16-bit words from a DDR serial stream framed by SYNC_IN into a 2-entry FIFO.
// Latency: PAR_VALID rises after the 8th rising edge following the SYNC edge.
// Backpressure: PAR_READY low holds the FIFO head; a word completing into a full FIFO is dropped (OVERFLOW).
module conv_tree_deserializer_16
    import conv_tree_pkg::*;
(
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          SERIAL_IN,
    input  logic                          SYNC_IN,
    input  logic                          CLR_ERR,
    conv_tree_deserializer_16_if.master   par,
    output logic                          ALIGN_ERR,
    output logic                          OVERFLOW
);

    pair_t  pair;
    state_e state_q;
    cnt_t   cnt_q;
    word_t  shreg_q;

    word_t  mem_q [FIFO_DEPTH];
    ptr_t   rd_ptr_q;
    ptr_t   wr_ptr_q;
    occ_t   occ_q;

    logic   align_err_q, align_err_d;
    logic   overflow_q,  overflow_d;

    logic   word_done;
    logic   mid_sync;
    word_t  done_word;
    logic   fifo_full;
    logic   pop;
    logic   push;
    logic   drop;

    ddr_input_capture u_capture (
        .CLK       (CLK),
        .RESET     (RESET),
        .SERIAL_IN (SERIAL_IN),
        .pair_o    (pair)
    );

    // Frame events and FIFO push/pop decisions for the current rising edge.
    always_comb begin
        word_done = (state_q == ST_SHIFT) && (cnt_q == LAST_PAIR);
        mid_sync  = (state_q == ST_SHIFT) && (cnt_q != LAST_PAIR) && SYNC_IN;
        // Last pair enters at the top; pair 0 has been shifted down to bits [1:0].
        done_word = {pair, shreg_q[WORD_W-1:2]};
        fifo_full = (occ_q == FIFO_FULL);
        pop       = par.PAR_VALID && par.PAR_READY;
        push      = word_done && (!fifo_full || pop);
        drop      = word_done && fifo_full && !pop;
    end

    // Framing FSM: IDLE waits for SYNC, SHIFT counts pairs and restarts on early or back-to-back SYNC.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (SYNC_IN) begin
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    shreg_q <= {pair, shreg_q[WORD_W-1:2]};
                    if (cnt_q == LAST_PAIR) begin
                        cnt_q   <= '0;
                        state_q <= SYNC_IN ? ST_SHIFT : ST_IDLE;
                    end else if (SYNC_IN) begin
                        // Early SYNC: partial word is abandoned; its stale bits shift out over the new frame.
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Output FIFO storage and pointers; a full FIFO accepts a push only when the head pops on the same edge.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= done_word;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    // Sticky error flags: a set on the same edge wins over CLR_ERR.
    always_comb begin
        align_err_d = mid_sync | (align_err_q & ~CLR_ERR);
        overflow_d  = drop     | (overflow_q  & ~CLR_ERR);
    end

    // Error flag registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            align_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            align_err_q <= align_err_d;
            overflow_q  <= overflow_d;
        end
    end

    assign par.PAR_OUT   = mem_q[rd_ptr_q];
    assign par.PAR_VALID = (occ_q != '0);
    assign ALIGN_ERR     = align_err_q;
    assign OVERFLOW      = overflow_q;

endmodule

// File: tb/tb_conv_tree_deserializer_16.sv
module tb_conv_tree_deserializer_16;

    logic CLK;
    logic RESET;
    logic SERIAL_IN;
    logic SYNC_IN;
    logic CLR_ERR;
    logic ALIGN_ERR;
    logic OVERFLOW;

    int vectors;
    int miscompares;

    conv_tree_deserializer_16_if par_if ();

    conv_tree_deserializer_16 dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .SERIAL_IN (SERIAL_IN),
        .SYNC_IN   (SYNC_IN),
        .CLR_ERR   (CLR_ERR),
        .par       (par_if),
        .ALIGN_ERR (ALIGN_ERR),
        .OVERFLOW  (OVERFLOW)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Present bit 2k before rising edge Ek (with optional SYNC), bit 2k+1 before the next falling edge.
    task automatic drive_pair(input logic rise_b, input logic fall_b, input logic sync);
        @(negedge CLK);
        #1;
        SERIAL_IN = rise_b;
        SYNC_IN   = sync;
        @(posedge CLK);
        #1;
        SERIAL_IN = fall_b;
        SYNC_IN   = 1'b0;
    endtask

    // Send pairs first..last of w LSB-first; SYNC accompanies pair 0.
    task automatic send_pairs(input logic [15:0] w, input int first, input int last);
        for (int k = first; k <= last; k++) begin
            drive_pair(w[2*k], w[2*k+1], k == 0);
        end
    endtask

    task automatic test_reset;
        RESET            = 1'b0;
        SERIAL_IN        = 1'b0;
        SYNC_IN          = 1'b0;
        CLR_ERR          = 1'b0;
        par_if.PAR_READY = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        vectors++; if (par_if.PAR_VALID !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", par_if.PAR_VALID); end
        vectors++; if (par_if.PAR_OUT !== 16'h0000) begin miscompares++; $display("FAIL reset_out: got %h want 0000", par_if.PAR_OUT); end
        vectors++; if (ALIGN_ERR !== 1'b0) begin miscompares++; $display("FAIL reset_align: got %b want 0", ALIGN_ERR); end
        vectors++; if (OVERFLOW !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b want 0", OVERFLOW); end
        @(negedge CLK);
        #1;
        RESET = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_single_word;
        par_if.PAR_READY = 1'b1;
        send_pairs(16'hC5AF, 0, 7);
        vectors++; if (par_if.PAR_VALID !== 1'b0) begin miscompares++; $display("FAIL single_early: valid %b before E8, want 0", par_if.PAR_VALID); end
        @(posedge CLK);
        #1;
        vectors++; if (par_if.PAR_VALID !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %b want 1", par_if.PAR_VALID); end
        vectors++; if (par_if.PAR_OUT !== 16'hC5AF) begin miscompares++; $display("FAIL single_out: got %h want c5af", par_if.PAR_OUT); end
        vectors++; if (ALIGN_ERR !== 1'b0 || OVERFLOW !== 1'b0) begin miscompares++; $display("FAIL single_flags: got align %b ovf %b want 0 0", ALIGN_ERR, OVERFLOW); end
        @(posedge CLK);
        #1;
        vectors++; if (par_if.PAR_VALID !== 1'b0) begin miscompares++; $display("FAIL single_one_cycle: got %b want 0", par_if.PAR_VALID); end
    endtask

    task automatic test_back_to_back;
        par_if.PAR_READY = 1'b1;
        send_pairs(16'h1234, 0, 7);
        send_pairs(16'hBEEF, 0, 0);
        vectors++; if (par_if.PAR_VALID !== 1'b1 || par_if.PAR_OUT !== 16'h1234) begin miscompares++; $display("FAIL b2b_first: got valid %b out %h want 1 1234", par_if.PAR_VALID, par_if.PAR_OUT); end
        send_pairs(16'hBEEF, 1, 1);
        vectors++; if (par_if.PAR_VALID !== 1'b0) begin miscompares++; $display("FAIL b2b_gap: got %b want 0", par_if.PAR_VALID); end
        send_pairs(16'hBEEF, 2, 7);
        @(posedge CLK);
        #1;
        vectors++; if (par_if.PAR_VALID !== 1'b1 || par_if.PAR_OUT !== 16'hBEEF) begin miscompares++; $display("FAIL b2b_second: got valid %b out %h want 1 beef", par_if.PAR_VALID, par_if.PAR_OUT); end
        vectors++; if (ALIGN_ERR !== 1'b0) begin miscompares++; $display("FAIL b2b_align: got %b want 0", ALIGN_ERR); end
        @(posedge CLK);
        #1;
        vectors++; if (par_if.PAR_VALID !== 1'b0) begin miscompares++; $display("FAIL b2b_drained: got %b want 0", par_if.PAR_VALID); end
    endtask

    task automatic test_overflow;
        par_if.PAR_READY = 1'b0;
        send_pairs(16'h0001, 0, 7);
        send_pairs(16'h0002, 0, 7);
        send_pairs(16'h0003, 0, 7);
        @(posedge CLK);
        #1;
        vectors++; if (OVERFLOW !== 1'b1) begin miscompares++; $display("FAIL ovf_flag: got %b want 1", OVERFLOW); end
        vectors++; if (par_if.PAR_VALID !== 1'b1 || par_if.PAR_OUT !== 16'h0001) begin miscompares++; $display("FAIL ovf_head: got valid %b out %h want 1 0001", par_if.PAR_VALID, par_if.PAR_OUT); end
        repeat (2) @(posedge CLK);
        #1;
        vectors++; if (par_if.PAR_OUT !== 16'h0001) begin miscompares++; $display("FAIL ovf_stable: got %h want 0001", par_if.PAR_OUT); end
        par_if.PAR_READY = 1'b1;
        @(posedge CLK);
        #1;
        vectors++; if (par_if.PAR_VALID !== 1'b1 || par_if.PAR_OUT !== 16'h0002) begin miscompares++; $display("FAIL ovf_second: got valid %b out %h want 1 0002", par_if.PAR_VALID, par_if.PAR_OUT); end
        @(posedge CLK);
        #1;
        vectors++; if (par_if.PAR_VALID !== 1'b0) begin miscompares++; $display("FAIL ovf_dropped: got valid %b out %h want 0", par_if.PAR_VALID, par_if.PAR_OUT); end
    endtask

    task automatic test_mid_sync;
        par_if.PAR_READY = 1'b1;
        send_pairs(16'hFFFF, 0, 2);
        send_pairs(16'hA5A5, 0, 7);
        vectors++; if (par_if.PAR_VALID !== 1'b0) begin miscompares++; $display("FAIL mid_no_partial: got valid %b out %h want 0", par_if.PAR_VALID, par_if.PAR_OUT); end
        vectors++; if (ALIGN_ERR !== 1'b1) begin miscompares++; $display("FAIL mid_align: got %b want 1", ALIGN_ERR); end
        @(posedge CLK);
        #1;
        vectors++; if (par_if.PAR_VALID !== 1'b1 || par_if.PAR_OUT !== 16'hA5A5) begin miscompares++; $display("FAIL mid_word: got valid %b out %h want 1 a5a5", par_if.PAR_VALID, par_if.PAR_OUT); end
        @(posedge CLK);
        #1;
        vectors++; if (par_if.PAR_VALID !== 1'b0) begin miscompares++; $display("FAIL mid_only_one: got %b want 0", par_if.PAR_VALID); end
    endtask

    task automatic test_clr_err;
        CLR_ERR = 1'b1;
        @(posedge CLK);
        #1;
        CLR_ERR = 1'b0;
        vectors++; if (ALIGN_ERR !== 1'b0 || OVERFLOW !== 1'b0) begin miscompares++; $display("FAIL clr_both: got align %b ovf %b want 0 0", ALIGN_ERR, OVERFLOW); end
        par_if.PAR_READY = 1'b0;
        send_pairs(16'h0011, 0, 7);
        send_pairs(16'h0022, 0, 7);
        send_pairs(16'h0033, 0, 7);
        CLR_ERR = 1'b1;
        @(posedge CLK);
        #1;
        CLR_ERR = 1'b0;
        vectors++; if (OVERFLOW !== 1'b1) begin miscompares++; $display("FAIL clr_set_wins: got %b want 1", OVERFLOW); end
        vectors++; if (par_if.PAR_OUT !== 16'h0011) begin miscompares++; $display("FAIL clr_head: got %h want 0011", par_if.PAR_OUT); end
    endtask

    task automatic test_reset_mid_word;
        send_pairs(16'hFFFF, 0, 3);
        @(negedge CLK);
        #1;
        RESET   = 1'b0;
        SYNC_IN = 1'b1;
        #1;
        vectors++; if (par_if.PAR_VALID !== 1'b0 || par_if.PAR_OUT !== 16'h0000) begin miscompares++; $display("FAIL rst_async_fifo: got valid %b out %h want 0 0000", par_if.PAR_VALID, par_if.PAR_OUT); end
        vectors++; if (OVERFLOW !== 1'b0 || ALIGN_ERR !== 1'b0) begin miscompares++; $display("FAIL rst_async_flags: got align %b ovf %b want 0 0", ALIGN_ERR, OVERFLOW); end
        repeat (2) @(posedge CLK);
        #1;
        SYNC_IN = 1'b0;
        @(negedge CLK);
        #1;
        RESET            = 1'b1;
        par_if.PAR_READY = 1'b1;
        repeat (9) @(posedge CLK);
        #1;
        vectors++; if (par_if.PAR_VALID !== 1'b0) begin miscompares++; $display("FAIL rst_no_stale: got %b want 0", par_if.PAR_VALID); end
        send_pairs(16'h00FF, 0, 7);
        @(posedge CLK);
        #1;
        vectors++; if (par_if.PAR_VALID !== 1'b1 || par_if.PAR_OUT !== 16'h00FF) begin miscompares++; $display("FAIL rst_new_word: got valid %b out %h want 1 00ff", par_if.PAR_VALID, par_if.PAR_OUT); end
        vectors++; if (ALIGN_ERR !== 1'b0 || OVERFLOW !== 1'b0) begin miscompares++; $display("FAIL rst_flags: got align %b ovf %b want 0 0", ALIGN_ERR, OVERFLOW); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset;
        test_single_word;
        test_back_to_back;
        test_overflow;
        test_mid_sync;
        test_clr_err;
        test_reset_mid_word;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/conv_tree_deserializer_16.md
CONV_TREE_DESERIALIZER_16 -- requirements
Module: conv_tree_deserializer_16

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single clock; data sampled on both edges.
REQ-002 SHALL have port RESET, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port SERIAL_IN, input, 1 bit: double-data-rate stream from conv_tree_serializer_16 SERIAL_OUT.
REQ-004 SHALL have port SYNC_IN, input, 1 bit: marks the rising edge carrying bit 0 of a word.
REQ-005 SHALL have port PAR_READY, input, 1 bit: consumer accepts PAR_OUT.
REQ-006 SHALL have port CLR_ERR, input, 1 bit: synchronous clear of sticky flags.
REQ-007 SHALL have port PAR_OUT, output, 16 bits: reassembled word, natural bit order.
REQ-008 SHALL have port PAR_VALID, output, 1 bit: PAR_OUT holds an unconsumed word.
REQ-009 SHALL have port ALIGN_ERR, output, 1 bit: sticky; SYNC_IN arrived mid-word.
REQ-010 SHALL have port OVERFLOW, output, 1 bit: sticky; a completed word was dropped.

Function
REQ-011 SHALL sample, from rising edge E0 at which SYNC_IN=1, SERIAL_IN at rising edge Ek as bit 2k and at the following falling edge as bit 2k+1, for k=0..7.
REQ-012 SHALL run an FSM with two states: IDLE, and SHIFT with a 3-bit pair counter 0..7.
REQ-013 SHALL go IDLE->SHIFT (count 0) on SYNC_IN=1; in SHIFT it increments the count each rising edge; after count 7 completes it returns to IDLE, or to SHIFT count 0 if SYNC_IN=1 at E8, giving back-to-back words with no gap.
REQ-014 SHALL ignore SERIAL_IN in IDLE.
REQ-015 SHALL push the completed word (PAR_OUT[i]=bit i) into a 2-entry FIFO at rising edge E8; PAR_VALID goes high after E8, so latency is 8 cycles from SYNC.
REQ-016 SHALL pop a FIFO entry at any rising edge with PAR_VALID=1 and PAR_READY=1; PAR_OUT/PAR_VALID SHALL present the FIFO head, in order, with no bubble.
REQ-017 SHALL handle a full FIFO at E8 as follows: with a pop on the same edge, the push succeeds; without a pop, the new word is dropped, OVERFLOW is set, and FIFO contents are unchanged.
REQ-018 SHALL, on SYNC_IN=1 at E1..E7, discard the partial word, set ALIGN_ERR, and restart at count 0 with that edge as the new E0.
REQ-019 SHALL clear ALIGN_ERR and OVERFLOW on CLR_ERR=1 at a rising edge; a same-edge set SHALL take priority over the clear.
REQ-020 SHALL keep PAR_OUT stable while PAR_VALID=1 and PAR_READY=0.

Reset
REQ-021 SHALL, on RESET=0 and immediately (asynchronously), empty the FIFO, force state to IDLE with count 0, and drive PAR_VALID=0, PAR_OUT=16'h0000, ALIGN_ERR=0, OVERFLOW=0.
REQ-022 SHALL discard any word in progress when reset is asserted mid-word; after release, the block waits for a fresh SYNC_IN.
REQ-023 SHALL hold all state in reset while RESET=0 regardless of SYNC_IN; the falling-edge capture flop is also reset.

Structure
REQ-024 SHALL take WORD_W=16, PAIRS=8, FIFO_DEPTH=2 and the FSM state enum from shared package conv_tree_pkg.
REQ-025 SHALL isolate the falling-edge capture in sub-module ddr_input_capture, which outputs a 2-bit pair {fall, rise} aligned to the rising edge; all other logic is rising-edge only.

Verification
REQ-026 SHALL verify a single word: SYNC at E0 and stream of 16'hC5AF LSB-first, PAR_READY=1 -> PAR_VALID=1 for one cycle after E8 with PAR_OUT=16'hC5AF and no flags set.
REQ-027 SHALL verify back-to-back words: 16'h1234 then 16'hBEEF with SYNC at E0 and E8, PAR_READY=1 -> two valid cycles after E8 and E16, in order.
REQ-028 SHALL verify backpressure/overflow: PAR_READY=0 with 3 words 16'h0001/16'h0002/16'h0003 -> FIFO holds 0001 and 0002, OVERFLOW=1; then PAR_READY=1 -> 0001 then 0002 delivered.
REQ-029 SHALL verify mid-word SYNC: SYNC at E0, again at E3, then 16'hA5A5 -> ALIGN_ERR=1, only 16'hA5A5 delivered, 8 cycles after the second SYNC.
REQ-030 SHALL verify reset mid-word: RESET=0 at E4, released, then new SYNC with 16'h00FF -> no word from the aborted frame, PAR_OUT=16'h00FF, flags 0.
REQ-031 SHALL verify CLR_ERR: CLR_ERR=1 with flags set -> both flags read 0 next cycle; CLR_ERR with a simultaneous overflow -> OVERFLOW stays 1.
